// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: multi-cycle WIDTH-bit adder/subtractor built around a single
// shared 4-bit carry-lookahead slice. It processes one nibble per cycle, LSB
// first, and keeps the inter-nibble carry in a register.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   in_valid_i   operand transfer request
//   in_ready_o   block can accept operands (IDLE and not in reset)
//   a_i, b_i     operands
//   cin_i        carry-in (add mode only)
//   sub_i        1 = a - b (cin ignored)
//   out_valid_o  result available
//   out_ready_i  consumer accepts the result
//   sum_o        result, modulo 2^WIDTH
//   cout_o       carry-out; in sub mode 1 = no borrow
//   ovf_o        two's-complement overflow
module cla_nibble_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned NN = WIDTH / 4;
  localparam int unsigned KW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [KW-1:0] KLast = KW'(NN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Shared 4-bit CLA slice
  logic [3:0] cla_a, cla_b, cla_g, cla_p, cla_sum;
  logic [4:0] cla_c;
  logic       cla_cout;
  logic       c_msb;

  always_comb begin
    cla_a = opa_q[{k_q, 2'b00} +: 4];
    cla_b = opb_q[{k_q, 2'b00} +: 4];
    cla_g = cla_a & cla_b;
    cla_p = cla_a ^ cla_b;
    // Each carry is expanded directly from carry_q so no bit depends on another.
    cla_c[0] = carry_q;
    cla_c[1] = cla_g[0] | (cla_p[0] & carry_q);
    cla_c[2] = cla_g[1] | (cla_p[1] & cla_g[0]) | (cla_p[1] & cla_p[0] & carry_q);
    cla_c[3] = cla_g[2] | (cla_p[2] & cla_g[1]) | (cla_p[2] & cla_p[1] & cla_g[0])
             | (cla_p[2] & cla_p[1] & cla_p[0] & carry_q);
    cla_c[4] = cla_g[3] | (cla_p[3] & cla_g[2]) | (cla_p[3] & cla_p[2] & cla_g[1])
             | (cla_p[3] & cla_p[2] & cla_p[1] & cla_g[0])
             | (cla_p[3] & cla_p[2] & cla_p[1] & cla_p[0] & carry_q);
    cla_sum  = cla_p ^ cla_c[3:0];
    cla_cout = cla_c[4];
    // Carry into the MSB, recovered from the MSB sum bit of the top nibble.
    c_msb    = opa_q[WIDTH-1] ^ opb_q[WIDTH-1] ^ cla_sum[3];
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          opa_d   = a_i;
          // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
          opb_d   = sub_i ? ~b_i : b_i;
          carry_d = sub_i | cin_i;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[{k_q, 2'b00} +: 4] = cla_sum;
        carry_d = cla_cout;
        if (k_q == KLast) begin
          cout_d  = cla_cout;
          ovf_d   = c_msb ^ cla_cout;
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q == StIdle) && !rst_i;
    out_valid_o = (state_q == StDone);
    sum_o       = sum_q;
    cout_o      = cout_q;
    ovf_o       = ovf_q;
  end

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Testbench for cla_nibble_seq (WIDTH=16): directed vector table, randomized
// operations against an arithmetic reference model, backpressure and
// mid-operation reset sequences.
module tb_cla_nibble_seq;

  localparam int unsigned W  = 16;
  localparam int          NN = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  cla_nibble_seq #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .sub_i      (sub),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_o      (sum),
    .cout_o     (cout),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sum for result/carry, signed integer range for overflow.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [16:0] u;
    int          r;
    logic        ov;
    if (ms) begin
      u = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
      r = int'($signed(ma)) - int'($signed(mb));
    end else begin
      u = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
      r = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    end
    ov = (r > 32767) || (r < -32768);
    return {ov, u[16], u[15:0]};
  endfunction

  // Issue one operation; returns the result once out_valid rises and, if
  // out_ready is high, completes the output handshake.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic ts, output logic [15:0] rs, output logic rc,
                        output logic ro, output int lat);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] rs, ra, rb;
    logic        rc, ro, rci, rsb;
    logic [17:0] exp;
    int          lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};

    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d sum", i), 32'(rs), 32'(vecs[i].sum));
      chk($sformatf("vec%0d cout", i), 32'(rc), 32'(vecs[i].cout));
      chk($sformatf("vec%0d ovf", i), 32'(ro), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(NN));
    end

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rci = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      exp = model(ra, rb, rci, rsb);
      run_op(ra, rb, rci, rsb, rs, rc, ro, lat);
      chk($sformatf("rand%0d {ovf,cout,sum}", i), 32'({ro, rc, rs}), 32'(exp));
      chk($sformatf("rand%0d latency", i), 32'(lat), 32'(NN));
    end

    // Backpressure: result held, no new accept while DONE
    out_ready = 1'b0;
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("bp sum", 32'(rs), 32'h3333);
    chk("bp latency", 32'(lat), 32'(NN));
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d sum", i), 32'(sum), 32'h3333);
      chk($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release sum kept", 32'(sum), 32'h3333);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp idle%0d out_valid", i), 32'(out_valid), 32'd0);
    end

    // Reset in the middle of RUN (nibble k=2)
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun rst out_valid", 32'(out_valid), 32'd0);
    chk("midrun rst in_ready", 32'(in_ready), 32'd0);
    chk("midrun rst {ovf,cout,sum}", 32'({ovf, cout, sum}), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("midrun no pulse%0d", i), 32'(out_valid), 32'd0);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("after rst sum", 32'(rs), 32'h1000);
    chk("after rst cout", 32'(rc), 32'd0);
    chk("after rst ovf", 32'(ro), 32'd0);
    chk("after rst latency", 32'(lat), 32'(NN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
